// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-nibble serial adder. Two W-bit operands (W = 4*NIBBLES) are taken in
//   through a valid/ready handshake. They are added one nibble per clock,
//   LSB first, by a 4-bit ripple adder (add4proc), with the carry chained
//   through a register. The assembled sum is then offered downstream through
//   a second valid/ready handshake.
//
//   Optional feature: define SERADD_OVF_EN to add the signed-overflow output ovf.
//
//   Ports
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   operands a/b/cin valid
//     in_ready   out  block can accept operands (IDLE only)
//     a, b       in   W-bit operands
//     cin        in   carry into nibble 0
//     out_valid  out  sum/cout (and ovf) valid
//     out_ready  in   downstream accepts result
//     sum        out  a + b + cin modulo 2^W
//     cout       out  carry out of the MSB nibble
//     ovf        out  two's-complement overflow (SERADD_OVF_EN only)

module add4proc (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready high, waiting for operands
// RUN   | adding nibble r_idx; result handed out after last nibble
// DONE  | out_valid high, result held until out_ready
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
`ifdef SERADD_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_in_ready;
  logic            r_out_valid;
`ifdef SERADD_OVF_EN
  logic            r_ovf;
`endif

  logic [3:0] w_nib_a;
  logic [3:0] w_nib_b;
  logic [3:0] w_nib_sum;
  logic       w_nib_cout;

  // Constant-index mux keeps the nibble select free of width-mismatched
  // arithmetic on r_idx and works for any NIBBLES, power of two or not.
  always_comb begin
    w_nib_a = 4'h0;
    w_nib_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_nib_a = r_a[4*i +: 4];
        w_nib_b = r_b[4*i +: 4];
      end
    end
  end

  add4proc u_add4 (
    .a    (w_nib_a),
    .b    (w_nib_b),
    .cin  (r_carry),
    .sum  (w_nib_sum),
    .cout (w_nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef SERADD_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= cin;
            r_idx      <= '0;
            r_sum      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDXW'(i)) begin
              r_sum[4*i +: 4] <= w_nib_sum;
            end
          end
          r_carry <= w_nib_cout;
          if (r_idx == LAST_IDX) begin
            r_cout      <= w_nib_cout;
`ifdef SERADD_OVF_EN
            // w_nib_sum[3] is sum[W-1] on the last nibble.
            r_ovf       <= (r_a[W-1] == r_b[W-1]) && (w_nib_sum[3] != r_a[W-1]);
`endif
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
`ifdef SERADD_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         in_ready;
  logic         out_valid;
  logic         cout;
  logic [W-1:0] sum;
`ifdef SERADD_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input string tag);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_val({tag, "_busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_result(input logic [W-1:0] exp_sum, input logic exp_cout, input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_latency"}, 32'(lat), 32'(NIB));
    check_val({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check_val({tag, "_cout"}, 32'(cout), 32'(exp_cout));
  endtask

  task automatic accept_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, "_ovalid_clr"}, 32'(out_valid), 32'd0);
    check_val({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; a = '0; b = '0;
    #12;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_sum", 32'(sum), 32'd0);
    check_val("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // out_ready in IDLE does nothing
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("idle_oready_ovalid", 32'(out_valid), 32'd0);
    check_val("idle_oready_iready", 32'(in_ready), 32'd1);

    // 1: basic add
    start_op(16'h0003, 16'h0005, 1'b0, "t1");
    wait_result(16'h0008, 1'b0, "t1");
`ifdef SERADD_OVF_EN
    check_val("t1_ovf", 32'(ovf), 32'd0);
`endif
    accept_result("t1");

    // 2: carry ripples through every nibble
    start_op(16'hFFFF, 16'h0001, 1'b0, "t2");
    wait_result(16'h0000, 1'b1, "t2");
    accept_result("t2");

    // carry-in with mixed nibbles
    start_op(16'hABCD, 16'h1234, 1'b1, "tc");
    wait_result(16'hBE02, 1'b0, "tc");
    accept_result("tc");

    // 3: with cin, then backpressure for 3 cycles
    start_op(16'h8000, 16'h7FFF, 1'b1, "t3");
    wait_result(16'h0000, 1'b1, "t3");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("t3_hold_ovalid", 32'(out_valid), 32'd1);
      check_val("t3_hold_sum", 32'(sum), 32'd0);
      check_val("t3_hold_cout", 32'(cout), 32'd1);
      check_val("t3_hold_iready", 32'(in_ready), 32'd0);
    end
    accept_result("t3");

    // 4: in_valid with new operands during RUN/DONE is ignored
    start_op(16'h0102, 16'h0304, 1'b0, "t4a");
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    wait_result(16'h0406, 1'b0, "t4a");
    accept_result("t4a");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("t4b_accepted", 32'(in_ready), 32'd0);
    wait_result(16'h2345, 1'b0, "t4b");
    accept_result("t4b");

    // 5: async reset mid-RUN at idx=2
    start_op(16'h1111, 16'h2222, 1'b0, "t5");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_val("t5_partial_sum", 32'(sum), 32'h0033);
    check_val("t5_partial_ovalid", 32'(out_valid), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_val("t5_rst_in_ready", 32'(in_ready), 32'd1);
    check_val("t5_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("t5_rst_sum", 32'(sum), 32'd0);
    check_val("t5_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(16'h00FF, 16'h0001, 1'b0, "t5b");
    wait_result(16'h0100, 1'b0, "t5b");
    accept_result("t5b");

`ifdef SERADD_OVF_EN
    // 6: signed overflow
    start_op(16'h7FFF, 16'h0001, 1'b0, "t6a");
    wait_result(16'h8000, 1'b0, "t6a");
    check_val("t6a_ovf", 32'(ovf), 32'd1);
    accept_result("t6a");
    start_op(16'hFFFF, 16'hFFFF, 1'b0, "t6b");
    wait_result(16'hFFFE, 1'b1, "t6b");
    check_val("t6b_ovf", 32'(ovf), 32'd0);
    accept_result("t6b");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
